// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring phase monitor: FSM state encoding and
// width-generic one-hot/rotation functions (vectors are zero-padded to RING_MAX_N).
package ring_pkg;

    localparam int unsigned RING_MAX_N = 64;

    typedef logic [RING_MAX_N-1:0] ring_vec_t;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_FAULT   = 2'd2
    } ring_state_t;

    // Rotate the low n bits of v left by one; bits at and above n are dropped.
    function automatic ring_vec_t rotl(input ring_vec_t v, input int unsigned n);
        ring_vec_t r;
        r = '0;
        for (int unsigned i = 0; i < RING_MAX_N; i++) begin
            if (i < n) begin
                r[(i + 1 == n) ? 0 : i + 1] = v[i];
            end
        end
        return r;
    endfunction

    function automatic logic onehot_valid(input ring_vec_t v, input int unsigned n);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < RING_MAX_N; i++) begin
            if (i < n && v[i]) begin
                cnt++;
            end
        end
        return (cnt == 1);
    endfunction

    // OR of set-bit indices: exact for a one-hot input, meaningless otherwise.
    function automatic int unsigned onehot_index(input ring_vec_t v, input int unsigned n);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < RING_MAX_N; i++) begin
            if (i < n && v[i]) begin
                idx |= i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ring_onehot_check.sv
// Combinational one-hot validity check and binary encoder for an N-bit ring state.
module ring_onehot_check
    import ring_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         vec,
    output logic                 valid,
    output logic [$clog2(N)-1:0] index
);

    localparam int unsigned PW = $clog2(N);

    always_comb begin
        valid = onehot_valid(ring_vec_t'(vec), N);
        index = '0;
        if (valid) begin
            index = PW'(onehot_index(ring_vec_t'(vec), N));
        end
    end

endmodule

// File: rtl/ring_phase_monitor.sv
// Monitors an upstream one-hot ring counter: tracks phase, locks onto a legal
// rotation sequence, counts revolutions and raises sticky error flags.
module ring_phase_monitor
    import ring_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned REV_W    = 8,
    parameter int unsigned LOCK_CNT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         ring_in,
    input  logic                 ring_en,
    input  logic                 clr_err,
    output logic [$clog2(N)-1:0] phase,
    output logic                 phase_valid,
    output logic                 wrap_pulse,
    output logic [REV_W-1:0]     rev_count,
    output logic                 locked,
    output logic                 err_onehot,
    output logic                 err_skip
);

    localparam int unsigned PW = $clog2(N);
    localparam int unsigned SW = $clog2(LOCK_CNT + 1);

    // s_q/e_q hold the previous sample and enable; the incoming ring_in is
    // judged against them at the same edge that registers it.
    logic [N-1:0]  s_q;
    logic          e_q;
    logic          h_q;
    ring_state_t   state;
    logic [SW-1:0] streak;

    logic          in_valid;
    logic [PW-1:0] in_index;
    logic [N-1:0]  expected;
    logic          mismatch;
    logic          legal;
    logic          clr_ok;

    ring_onehot_check #(.N(N)) u_check (
        .vec   (ring_in),
        .valid (in_valid),
        .index (in_index)
    );

    always_comb begin
        expected = e_q ? N'(rotl(ring_vec_t'(s_q), N)) : s_q;
        mismatch = in_valid && h_q && (ring_in != expected);
        legal    = in_valid && !mismatch;
        // A violation in the same cycle as clr_err keeps the flags set.
        clr_ok   = clr_err && legal;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q         <= '0;
            e_q         <= 1'b0;
            h_q         <= 1'b0;
            state       <= ST_ACQUIRE;
            streak      <= '0;
            phase       <= '0;
            phase_valid <= 1'b0;
            wrap_pulse  <= 1'b0;
            rev_count   <= '0;
            locked      <= 1'b0;
            err_onehot  <= 1'b0;
            err_skip    <= 1'b0;
        end else begin
            s_q         <= ring_in;
            e_q         <= ring_en;
            h_q         <= 1'b1;
            phase       <= in_index;
            phase_valid <= in_valid;
            wrap_pulse  <= 1'b0;
            err_onehot  <= (err_onehot & ~clr_ok) | ~in_valid;
            err_skip    <= (err_skip & ~clr_ok) | ((state == ST_LOCKED) && mismatch);

            case (state)
                ST_ACQUIRE: begin
                    if (legal) begin
                        if (32'(streak) + 1 >= LOCK_CNT) begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                            streak <= '0;
                        end else begin
                            streak <= streak + 1'b1;
                        end
                    end else begin
                        streak <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (!legal) begin
                        state  <= ST_FAULT;
                        locked <= 1'b0;
                    end else if (s_q[N-1] && ring_in[0]) begin
                        wrap_pulse <= 1'b1;
                        rev_count  <= rev_count + 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (clr_ok) begin
                        state  <= ST_ACQUIRE;
                        streak <= '0;
                    end
                end
                default: begin
                    state  <= ST_ACQUIRE;
                    locked <= 1'b0;
                    streak <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed table-driven bench for ring_phase_monitor (default build and REV_W=2 build).
module tb_ring_phase_monitor;

    logic       clk;
    logic       rst_n;
    logic [3:0] ring_in;
    logic       ring_en;
    logic       clr_err;

    logic [1:0] phase,   phase_b;
    logic       pv,      pv_b;
    logic       wrap,    wrap_b;
    logic [7:0] rev;
    logic [1:0] rev_b;
    logic       locked,  locked_b;
    logic       eo,      eo_b;
    logic       es,      es_b;

    ring_phase_monitor dut (
        .clk(clk), .rst_n(rst_n), .ring_in(ring_in), .ring_en(ring_en), .clr_err(clr_err),
        .phase(phase), .phase_valid(pv), .wrap_pulse(wrap), .rev_count(rev),
        .locked(locked), .err_onehot(eo), .err_skip(es)
    );

    ring_phase_monitor #(.REV_W(2)) dut_r2 (
        .clk(clk), .rst_n(rst_n), .ring_in(ring_in), .ring_en(ring_en), .clr_err(clr_err),
        .phase(phase_b), .phase_valid(pv_b), .wrap_pulse(wrap_b), .rev_count(rev_b),
        .locked(locked_b), .err_onehot(eo_b), .err_skip(es_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] ring;
        logic       en;
        logic       clr;
        int         ph;
        logic       pv;
        logic       wr;
        logic       lk;
        logic       eo;
        logic       es;
        int         rev;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic [3:0] ring, input logic en, input logic clr,
                       input int ph, input logic pv_e, input logic wr, input logic lk,
                       input logic eo_e, input logic es_e, input int rv);
        vec_t v;
        v.rst_n = r; v.ring = ring; v.en = en; v.clr = clr;
        v.ph = ph; v.pv = pv_e; v.wr = wr; v.lk = lk; v.eo = eo_e; v.es = es_e; v.rev = rv;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%0d expected=%0d", name, idx, act, exp_v);
        end
    endtask

    initial begin
        rst_n = 1'b0; ring_in = 4'b0001; ring_en = 1'b0; clr_err = 1'b0;

        //   rst ring     en clr ph pv wr lk eo es rev
        add(0, 4'b0001, 1, 0, 0, 0, 0, 0, 0, 0, 0);  // reset state
        add(1, 4'b0001, 1, 0, 0, 1, 0, 0, 0, 0, 0);  // first sample, no history
        add(1, 4'b0010, 1, 0, 1, 1, 0, 1, 0, 0, 0);  // second legal -> locked
        add(1, 4'b0100, 1, 0, 2, 1, 0, 1, 0, 0, 0);
        add(1, 4'b1000, 1, 0, 3, 1, 0, 1, 0, 0, 0);
        add(1, 4'b0001, 1, 0, 0, 1, 1, 1, 0, 0, 1);  // wrap
        add(1, 4'b0010, 1, 0, 1, 1, 0, 1, 0, 0, 1);
        add(1, 4'b1000, 0, 0, 3, 1, 0, 0, 0, 1, 1);  // skip 0010->1000 -> fault
        add(1, 4'b1000, 1, 1, 3, 1, 0, 0, 0, 0, 1);  // clear -> acquire
        add(1, 4'b0001, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        add(1, 4'b0010, 1, 0, 1, 1, 0, 1, 0, 0, 1);  // relock
        add(1, 4'b0100, 0, 0, 2, 1, 0, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++)
            add(1, 4'b0100, 0, 0, 2, 1, 0, 1, 0, 0, 1);  // held ring
        add(1, 4'b0100, 1, 0, 2, 1, 0, 1, 0, 0, 1);
        add(1, 4'b1000, 1, 0, 3, 1, 0, 1, 0, 0, 1);
        add(1, 4'b0001, 1, 0, 0, 1, 1, 1, 0, 0, 2);
        add(1, 4'b0100, 1, 0, 2, 1, 0, 0, 0, 1, 2);  // mismatch -> fault
        add(1, 4'b0001, 1, 1, 0, 1, 0, 0, 0, 1, 2);  // clr with mismatch: stays
        add(1, 4'b0010, 1, 0, 1, 1, 0, 0, 0, 1, 2);  // legal but no clr: holds
        add(1, 4'b0100, 1, 1, 2, 1, 0, 0, 0, 0, 2);  // clear -> acquire
        add(1, 4'b1000, 1, 0, 3, 1, 0, 0, 0, 0, 2);
        add(1, 4'b0110, 1, 0, 0, 0, 0, 0, 1, 0, 2);  // not one-hot in acquire
        add(1, 4'b0001, 1, 0, 0, 1, 0, 0, 1, 0, 2);  // mismatch vs rotl(0110)
        add(1, 4'b0010, 1, 0, 1, 1, 0, 0, 1, 0, 2);
        add(1, 4'b0100, 1, 0, 2, 1, 0, 1, 1, 0, 2);
        add(1, 4'b1000, 1, 0, 3, 1, 0, 1, 1, 0, 2);
        add(1, 4'b0001, 1, 0, 0, 1, 1, 1, 1, 0, 3);
        add(1, 4'b0010, 1, 1, 1, 1, 0, 1, 0, 0, 3);  // clr while locked
        add(0, 4'b0100, 1, 1, 0, 0, 0, 0, 0, 0, 0);  // reset mid-revolution
        add(1, 4'b0100, 1, 0, 2, 1, 0, 0, 0, 0, 0);

        // Five full revolutions from reset.
        add(0, 4'b0001, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k <= 20; k++) begin
            logic [3:0] r;
            r = 4'(1 << (k % 4));
            add(1, r, 1, 0, k % 4, 1, (k > 0 && k % 4 == 0), (k >= 1), 0, 0, k / 4);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n   = vecs[i].rst_n;
            ring_in = vecs[i].ring;
            ring_en = vecs[i].en;
            clr_err = vecs[i].clr;
            @(posedge clk);
            #1;
            chk("phase",       i, int'(phase),    vecs[i].ph);
            chk("phase_valid", i, int'(pv),       int'(vecs[i].pv));
            chk("wrap_pulse",  i, int'(wrap),     int'(vecs[i].wr));
            chk("locked",      i, int'(locked),   int'(vecs[i].lk));
            chk("err_onehot",  i, int'(eo),       int'(vecs[i].eo));
            chk("err_skip",    i, int'(es),       int'(vecs[i].es));
            chk("rev_count",   i, int'(rev),      vecs[i].rev % 256);
            chk("rev_count_w2", i, int'(rev_b),   vecs[i].rev % 4);
            chk("wrap_pulse_w2", i, int'(wrap_b), int'(vecs[i].wr));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_phase_monitor.md
RING_PHASE_MONITOR -- requirements
Module: ring_phase_monitor

Interface
REQ-001 Parameter N, default 4: ring width, i.e. the number of one-hot phase bits; N >= 2.
REQ-002 Parameter REV_W, default 8: width of the revolution counter.
REQ-003 Parameter LOCK_CNT, default 2: consecutive legal samples required to lock; LOCK_CNT >= 1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 ring_in  input  N  one-hot ring counter state; the upstream ring rotates bit i to bit i+1 and bit N-1 to bit 0; its reset value is 1 in bit 0 only.
REQ-007 ring_en  input  1  the same enable that advances the upstream ring in this cycle.
REQ-008 clr_err  input  1  clears the sticky error flags and leaves FAULT.
REQ-009 phase  output  $clog2(N)  binary index of the sampled one-hot bit.
REQ-010 phase_valid  output  1  the sampled ring_in had exactly one bit set.
REQ-011 wrap_pulse  output  1  one-cycle pulse on a locked N-1 to 0 transition.
REQ-012 rev_count  output  REV_W  count of completed revolutions.
REQ-013 locked  output  1  high while the FSM is in LOCKED.
REQ-014 err_onehot  output  1  sticky flag: an illegal (not one-hot) sample was seen.
REQ-015 err_skip  output  1  sticky flag: a sequence violation was seen while LOCKED.

Function
REQ-016 ring_in and ring_en SHALL be registered every cycle as sample S and enable E; all outputs derive from these registers, giving 1-cycle latency.
REQ-017 phase SHALL equal the index of the set bit of S when phase_valid=1, else 0.
REQ-018 A history-valid bit H SHALL be set one cycle after reset and held until reset; no comparison occurs while H=0.
REQ-019 Expected sample SHALL be rotl(S_prev,1) if E_prev=1, else S_prev; a sample is legal when it is one-hot and, with H=1, equals the expected value.
REQ-020 FSM states SHALL be ACQUIRE, LOCKED and FAULT.
REQ-021 ACQUIRE: each legal sample increments the streak counter; an illegal or mismatched sample zeroes it; at streak = LOCK_CNT the FSM goes to LOCKED.
REQ-022 LOCKED: any non-one-hot or mismatched sample SHALL move the FSM to FAULT in the same edge that sets the flag.
REQ-023 FAULT: the FSM SHALL hold until clr_err=1, then go to ACQUIRE with the streak counter at 0.
REQ-024 err_onehot SHALL be set by a non-one-hot sample in any state; err_skip SHALL be set only by a LOCKED mismatch.
REQ-025 wrap_pulse SHALL be high for exactly one cycle when locked=1, S_prev[N-1]=1, S[0]=1 and the sample is legal.
REQ-026 rev_count SHALL increment on each wrap_pulse, wrap modulo 2^REV_W, and hold its value in ACQUIRE and FAULT.
REQ-027 If clr_err is asserted in the same cycle as a new violation, the violation SHALL win: the flag stays set and the FSM stays in or enters FAULT.
REQ-028 A sample with ring_en held low (repeated value) SHALL be legal and SHALL produce no wrap_pulse.

Reset
REQ-029 When rst_n=0 at a clock edge, the following SHALL reset:
- S to 0, E to 0, H to 0;
- FSM to ACQUIRE, streak counter to 0;
- phase, phase_valid, wrap_pulse, rev_count, locked, err_onehot and err_skip to 0.
REQ-030 Reset asserted mid-operation SHALL take effect on the next edge regardless of state or clr_err.

Structure
REQ-031 Package ring_pkg SHALL hold:
- the FSM state enum;
- the rotl and one-hot validity/encode functions, parameterised by N.
REQ-032 One sub-module, ring_onehot_check (combinational: one-hot valid plus binary index), SHALL be instantiated once.

Verification
REQ-033 Reset, then ring 0001,0010,0100,1000,0001 with ring_en=1 -> locked=1 after two legal samples; wrap_pulse one cycle; rev_count=1.
REQ-034 Locked, ring jumps 0010 to 1000 -> err_skip=1, locked=0; clr_err pulse -> ACQUIRE; relock after 2 legal samples.
REQ-035 ring_in=0110 in ACQUIRE -> phase_valid=0, err_onehot=1, err_skip=0, streak reset to 0.
REQ-036 ring_en=0 for 5 cycles while locked at 0100 -> locked stays 1, no errors, no wrap_pulse.
REQ-037 REV_W=2, 5 full revolutions -> rev_count sequence 1,2,3,0,1.
REQ-038 clr_err together with a mismatch -> err_skip stays 1, FSM stays FAULT; rst_n=0 mid-revolution -> all outputs 0 next edge.
